// File: rtl/m_unit_pcpi_issue.sv
// PCPI issue/retire sequencer for riscv_m_unit: decodes RV32M and custom
// modular-arithmetic instructions, issues them once, and retires the result under a watchdog.
module m_unit_pcpi_issue #(
  parameter logic [6:0] OPCODE_M       = 7'b0110011,
  parameter logic [6:0] OPCODE_CUSTOM  = 7'b0001011,
  parameter logic [7:0] CUSTOM_F3_MASK = 8'b0000_0111,
  parameter int         TIMEOUT        = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        timeout_err,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_busy,
  input  logic        m_ready
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             abort_reg, abort_next;
  logic             insn_match;
  logic             accept;
  logic             result_hit;
  logic             watchdog_hit;
  logic             retire;

  // Busy is purely informational; completion is signalled by m_ready alone.
  logic unused_busy;
  assign unused_busy = m_busy;

  assign insn_match = (pcpi_insn[31:25] == 7'b0000001) &&
                      ((pcpi_insn[6:0] == OPCODE_M) ||
                       ((pcpi_insn[6:0] == OPCODE_CUSTOM) && CUSTOM_F3_MASK[pcpi_insn[14:12]]));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      abort_reg <= abort_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    abort_next   = abort_reg;
    accept       = 1'b0;
    result_hit   = 1'b0;
    watchdog_hit = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (pcpi_valid && insn_match) begin
          accept     = 1'b1;
          cnt_next   = '0;
          abort_next = 1'b0;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        abort_next = abort_reg | ~pcpi_valid;
        if (m_ready) begin
          result_hit = 1'b1;
          state_next = S_RESP;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        abort_next = abort_reg | ~pcpi_valid;
        cnt_next   = cnt_reg + CNT_W'(1);
        // A result arriving in the final watchdog cycle still wins.
        if (m_ready) begin
          result_hit = 1'b1;
          state_next = S_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          watchdog_hit = 1'b1;
          state_next   = S_RESP;
        end
      end
      S_RESP:  state_next = S_DRAIN;
      S_DRAIN: if (!pcpi_valid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so each one is a plain flop.
  assign retire = (result_hit || watchdog_hit) && !abort_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi_wr       <= 1'b0;
      pcpi_rd       <= '0;
      pcpi_wait     <= 1'b0;
      pcpi_ready    <= 1'b0;
      timeout_err   <= 1'b0;
      m_valid       <= 1'b0;
      m_instruction <= '0;
      m_rs1         <= '0;
      m_rs2         <= '0;
    end else begin
      m_valid     <= accept;
      pcpi_wait   <= (state_next == S_ISSUE) || (state_next == S_WAIT);
      pcpi_ready  <= retire;
      pcpi_wr     <= retire && result_hit && m_wr;
      pcpi_rd     <= (retire && result_hit) ? m_rd : '0;
      timeout_err <= watchdog_hit;
      if (accept) begin
        m_instruction <= pcpi_insn;
        m_rs1         <= pcpi_rs1;
        m_rs2         <= pcpi_rs2;
      end
    end
  end

endmodule

// File: doc/m_unit_pcpi_issue.md
# m_unit_pcpi_issue

Issue/retire sequencer between the core's PCPI co-processor port and `riscv_m_unit`. It decodes the offered instruction, accepts only RV32M and custom modular-arithmetic (ADDMOD/SUBMOD/MODQ) encodings, and latches the operands. It then drives a single-cycle `valid` into the M unit, waits for `ready`, and returns the result to the core as a one-cycle `pcpi_ready` pulse. A watchdog bounds the wait, so a hung M unit cannot stall the core forever.

## Interface

- `OPCODE_M`, 7'b0110011: standard OP opcode for RV32M.
- `OPCODE_CUSTOM`, 7'b0001011: custom-0 opcode for the modular-arithmetic instructions.
- `CUSTOM_F3_MASK`, 8'b0000_0111: bit i set means custom funct3 = i is accepted.
- `TIMEOUT`, 64: maximum WAIT cycles before a forced retire (≥2).

- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pcpi_valid` in 1: core offers an instruction; held until `pcpi_ready` or abort.
- `pcpi_insn` in 32: offered instruction.
- `pcpi_rs1`, `pcpi_rs2` in 32: operand values.
- `pcpi_wr` out 1: write `pcpi_rd` to the destination register (valid with `pcpi_ready`).
- `pcpi_rd` out 32: result.
- `pcpi_wait` out 1: the instruction is claimed and in progress.
- `pcpi_ready` out 1: one-cycle retire pulse.
- `timeout_err` out 1: one-cycle pulse on a watchdog retire.
- `m_valid` out 1: start pulse to the M unit.
- `m_instruction` out 32: latched instruction.
- `m_rs1`, `m_rs2` out 32: latched operands.
- `m_wr` in 1: M unit write flag.
- `m_rd` in 32: M unit result.
- `m_busy` in 1: M unit busy (status only; not used for control).
- `m_ready` in 1: M unit result valid.

## Operation

**Decode match**
- funct7 (insn[31:25]) == 7'b0000001, AND
- either opcode == `OPCODE_M` (any funct3), or opcode == `OPCODE_CUSTOM` with `CUSTOM_F3_MASK[funct3]` = 1.
- Non-matching instructions are never claimed. All outputs stay at idle values, so the core's own illegal-instruction timeout handles them.

**FSM states:** IDLE, ISSUE, WAIT, RESP, DRAIN.
- **IDLE:** on `pcpi_valid` & match, latch insn/rs1/rs2 into the `m_*` registers, clear the abort flag and watchdog counter, then go to ISSUE.
- **ISSUE:** `m_valid`=1 for exactly this cycle. If `m_ready` is high, capture result and go to RESP. Otherwise go to WAIT.
- **WAIT:** the counter increments each cycle.
  - On `m_ready`, capture `m_wr`/`m_rd`, then go to RESP.
  - Else, when the counter reaches `TIMEOUT`-1, capture wr=0/rd=0, pulse `timeout_err`, and go to RESP.
- **RESP:** if the abort flag is clear, `pcpi_ready`=1 for one cycle; otherwise no pulse. Then go to DRAIN.
- **DRAIN:** stay until `pcpi_valid`=0, then go to IDLE. This prevents re-issuing the same instruction while the core is still holding `pcpi_valid`.

**Boundary conditions**
- **Abort:** `pcpi_valid`=0 in any cycle of ISSUE or WAIT sets the abort flag. The M-unit operation still runs to completion (or timeout), and the result is discarded.
- **Late `m_ready`:** an `m_ready` arriving in RESP, DRAIN, or IDLE, including one after a timeout, is ignored.
- **Output stability:** `m_instruction`/`m_rs1`/`m_rs2` hold their values until the next accept.
- **Idle values:** `pcpi_wr` and `pcpi_rd` are 0 whenever `pcpi_ready`=0.

## Timing

- **Reset** (async assert, sync release), all outputs 0: `pcpi_wr`, `pcpi_rd`, `pcpi_wait`, `pcpi_ready`, `timeout_err`, `m_valid`, `m_instruction`, `m_rs1`, `m_rs2`. State goes to IDLE and the counter and abort flag are cleared. A reset mid-operation abandons the instruction and issues no `pcpi_ready`.
- **Registering:** all outputs are registered, with no combinational path from any input to any output.
- **Cycle sequence:** accept on edge N; `m_valid` high in cycle N+1; `m_ready` first observed in cycle N+1+k (k≥0); `pcpi_ready` high in cycle N+2+k.
  - Minimum accept-to-retire is 2 cycles.
  - On timeout, `pcpi_ready` follows exactly `TIMEOUT`+1 cycles after ISSUE.
- **`pcpi_wait`:** high in ISSUE and WAIT, low in RESP.
- **Throughput:** at most one instruction in flight. The next accept happens no earlier than the first cycle `pcpi_valid` is seen low in DRAIN, followed by IDLE.

## Test plan

- **MUL round trip:** MUL insn 32'h02000033, rs1=32'h1111FFFF, rs2=32'h1111FFFF, M-unit model returns 32'hDDDC0001 three cycles after `m_valid` → exactly one `m_valid` pulse carrying the latched operands; `pcpi_ready`=1, `pcpi_wr`=1, `pcpi_rd`=32'hDDDC0001 for one cycle; `pcpi_wait` high throughout.
- **Custom decode:** custom ADDMOD (funct3=0) is accepted, and funct3=5 with default mask is not claimed. funct7=0 on opcode 0110011 (plain ADD) is not claimed. For both rejects, `pcpi_wait`/`m_valid` stay 0 for 20 cycles.
- **Watchdog:** model never asserts `m_ready`, `TIMEOUT`=8 → `timeout_err` and `pcpi_ready` pulse, `pcpi_wr`=0, `pcpi_rd`=0. A late `m_ready` 5 cycles later causes no second pulse.
- **Abort:** drop `pcpi_valid` two cycles into WAIT, with the result arriving later → no `pcpi_ready`. The block returns to IDLE and the next DIVU 13/5 retires with `pcpi_rd`=2.
- **No double issue:** hold `pcpi_valid` high 4 cycles past `pcpi_ready` → a single `m_valid` pulse total, with state DRAIN until `pcpi_valid` falls.
- **Async reset:** assert `resetn`=0 mid-WAIT → all outputs 0 immediately. After release, a MULHU FFFFFFFF×FFFFFFFF returns 32'hFFFFFFFE normally.
